// File: rtl/inst_fetch_unit.sv
`timescale 1ns/1ps
// inst_fetch_unit
//   Instruction-fetch front end for an SRAM-like instruction port.
//   - Generates sequential PCs and issues one single-word read at a time.
//   - Buffers responses in a 2-entry {pc, inst} queue for decode.
//   - A branch redirect flushes the queue and retargets the fetch PC.
//   - Any response still in flight when the redirect arrives is discarded.
// Ports
//   aclk, aresetn           : clock, asynchronous active-low reset
//   inst_sram_*             : SRAM-like read request/response channel
//                             (write-side fields tied off)
//   br_taken, br_target     : single-cycle redirect pulse and target PC
//   fs_valid/fs_pc/fs_inst  : queue head presented to decode
//   ds_allowin              : decode accepts the head this cycle
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        aclk,
  input  logic        aresetn,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  input  logic        ds_allowin
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        discard_q, discard_d;
  // Redirect arrived while a request was presented but not yet accepted:
  // the old address must stay on the bus, and its response must be dropped.
  logic        stale_q, stale_d;

  logic [31:0] pc_mem_q   [2];
  logic [31:0] inst_mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q;

  logic accept, resp, push, pop;

  assign accept = (state_q == S_REQ)  && inst_sram_addr_ok;
  assign resp   = (state_q == S_WAIT) && inst_sram_data_ok;
  assign push   = resp && !discard_q && !br_taken;
  assign pop    = fs_valid && ds_allowin && !br_taken;

  assign inst_sram_req   = (state_q == S_REQ);
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = '0;
  assign inst_sram_wdata = '0;
  // addr_q is the latched request address; outside REQ show the next PC.
  assign inst_sram_addr  = (state_q == S_REQ) ? addr_q : fetch_pc_q;

  assign fs_valid = (count_q != 2'd0);
  assign fs_pc    = pc_mem_q[rd_ptr_q];
  assign fs_inst  = inst_mem_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    addr_d        = addr_q;
    inflight_pc_d = inflight_pc_q;
    discard_d     = discard_q;
    stale_d       = stale_q;

    case (state_q)
      S_IDLE: begin
        // Only one request outstanding, so in IDLE room means count < 2.
        if (count_q < 2'd2) state_d = S_REQ;
      end
      S_REQ: begin
        if (accept) begin
          state_d       = S_WAIT;
          inflight_pc_d = addr_q;
          // After a stale request fetch_pc already holds the redirect target.
          fetch_pc_d    = stale_q ? fetch_pc_q : fetch_pc_q + 32'd4;
          discard_d     = stale_q;
          stale_d       = 1'b0;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (br_taken) begin
      fetch_pc_d = br_target;
      case (state_q)
        S_REQ: begin
          if (inst_sram_addr_ok) discard_d = 1'b1;
          else                   stale_d   = 1'b1;
        end
        S_WAIT: begin
          if (!inst_sram_data_ok) discard_d = 1'b1;
        end
        default: ;
      endcase
    end

    if ((state_d == S_REQ) && (state_q != S_REQ)) addr_d = fetch_pc_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      addr_q        <= RESET_PC;
      inflight_pc_q <= '0;
      discard_q     <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      addr_q        <= addr_d;
      inflight_pc_q <= inflight_pc_d;
      discard_q     <= discard_d;
      stale_q       <= stale_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < 2; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (br_taken) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
        inst_mem_q[wr_ptr_q] <= inst_sram_rdata;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: ;
      endcase
    end
  end

endmodule
